cbrt_feeder: RTL
================

Name: cbrt_feeder

Overview:
Front-end stage that feeds the iterative cube-root core (`cbrt`) and consumes its results. It buffers incoming 8-bit samples in a small FIFO and launches one core operation per sample through the core's start/busy handshake. Each root is returned, paired with its operand, on a valid/ready output port. A per-operation watchdog and a completion counter support system bring-up.

Parameters:
DEPTH, 4, input FIFO depth in samples; must be a power of two, ≥2
TIMEOUT_CYCLES, 2000, maximum WAIT cycles before an operation is declared hung
CNT_W, 16, width of done_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets the block)
in_valid  input  1  upstream sample valid
in_data  input  8  sample x
in_ready  output  1  FIFO can accept a sample
cbrt_x  output  8  operand to core x_i
cbrt_start  output  1  one-cycle launch pulse to core start
cbrt_busy  input  1  core busy
cbrt_result  input  3  core result
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_x  output  8  operand belonging to out_root
out_root  output  3  floor cube root of out_x
out_timeout  output  1  result is invalid because the core hung
done_count  output  CNT_W  count of results accepted downstream

Behaviour:
- Reset (rst==0 at an edge) clears the following:
  - FIFO emptied; FSM to IDLE.
  - cbrt_start=0, cbrt_x=0.
  - out_valid=0, out_x=0, out_root=0, out_timeout=0.
  - done_count=0, watchdog=0.
- in_valid is ignored while rst==0.
- A reset mid-operation abandons that operation silently. Resetting the core is the system reset's job, not this block's.
- FIFO:
  - in_ready = !full; a push occurs when in_valid && in_ready.
  - When full, in_ready=0; there is no pass-through on a simultaneous pop.
  - A pop occurs only on the transition into START. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, HOLD.
  - IDLE: if FIFO is non-empty, pop the head into x_reg and go to START. Otherwise stay.
  - START (exactly 1 cycle): cbrt_start=1, cbrt_x=x_reg, watchdog cleared. Go to WAIT.
  - WAIT: cbrt_x stays x_reg, because the core may sample x_i at any point in its operation.
    - The core raises busy in the cycle after start is sampled, so the first WAIT cycle already sees busy==1.
    - If cbrt_busy==0: register out_root=cbrt_result, out_x=x_reg, out_timeout=0, and go to HOLD.
    - Else if watchdog==TIMEOUT_CYCLES-1: register out_root=0, out_x=x_reg, out_timeout=1, and go to HOLD.
    - Else watchdog++.
  - HOLD: out_valid=1; all out_* fields are stable until the handshake.
    - On out_ready, increment done_count (wraps at 2^CNT_W). Then, if the FIFO is non-empty, pop and go to START (back-to-back); else go to IDLE.
- Timing:
  - Latency from the accepting cycle (c0) of an empty, idle block: IDLE is seen in c1, cbrt_start is high in c2.
  - out_valid rises in the cycle after the WAIT cycle that sees busy==0.
- Outputs:
  - cbrt_start is high only in START, never for two consecutive cycles.
  - out_valid is high only in HOLD.
  - All outputs are registered except in_ready.
- A push in the same cycle as a pop is allowed whenever the FIFO is not full; occupancy stays constant.

Decomposition:
- Package cbrt_pkg holds:
  - X_W=8 and ROOT_W=3.
  - The feeder state enum {IDLE, START, WAIT, HOLD}.
  - The default TIMEOUT_CYCLES.
- One sub-module, cbrt_in_fifo: synchronous FIFO parameterised by DEPTH and width X_W. It has push/pop/full/empty and a read-data head and takes the same active-low synchronous rst.
- Bench pairing: the FSM and watchdog live in cbrt_feeder. The bench connects cbrt_feeder to a real cbrt instance (with its active-high reset driven as !rst) or to a behavioural core model.

Test Plan:
- Single sample: push 27 into an idle block with out_ready=1. Required: cbrt_start pulses in c2 with cbrt_x=27; result out_x=27, out_root=3, out_timeout=0; done_count=1.
- Burst: push 64, 125, 216, 8 back-to-back with out_ready=1. Required:
  - in_ready stays 1, since DEPTH=4.
  - Outputs appear in order: (64,4), (125,5), (216,6), (8,2).
  - Exactly one cbrt_start per sample; done_count=4.
- Full/backpressure: out_ready=0 and push 6 samples. Required: the first sample is in HOLD, four samples sit in the FIFO, in_ready=0, and the 6th sample is stalled. Releasing out_ready drains all 6 in order.
- Boundaries: push 0 and then 255. Required: roots 0 and 6; cbrt_x holds 255 for the whole WAIT phase.
- Hung core: the core model holds busy=1 forever. Required:
  - After TIMEOUT_CYCLES WAIT cycles, out_valid=1 with out_timeout=1, out_root=0.
  - The next sample then launches normally.
- Reset mid-op: drive rst=0 for one cycle during WAIT with 2 samples queued. Required: out_valid=0, in_ready=1, done_count=0, no further cbrt_start, and the FIFO is empty.

Source files
------------

// File: rtl/cbrt_pkg.sv
// rtl/cbrt_pkg.sv - shared widths, defaults and state type for the cube-root feeder
//
// Purpose: common definitions imported by cbrt_in_fifo and cbrt_feeder.
//   X_W            : operand width
//   ROOT_W         : root width (floor cube root of 255 is 6)
//   TIMEOUT_CYCLES : default watchdog limit in WAIT cycles
//   feeder_state_t : feeder FSM states
package cbrt_pkg;

  localparam int X_W            = 8;
  localparam int ROOT_W         = 3;
  localparam int TIMEOUT_CYCLES = 2000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/cbrt_in_fifo.sv
// rtl/cbrt_in_fifo.sv - synchronous sample FIFO in front of the cube-root core
//
// Purpose: buffers input samples; head shows the oldest entry while not empty.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset, empties the FIFO
//   push       : write push_data (ignored when full)
//   push_data  : sample to store
//   pop        : discard head (ignored when empty)
//   head       : oldest stored sample
//   full/empty : occupancy flags
module cbrt_in_fifo
  import cbrt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = X_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cbrt_feeder.sv
// rtl/cbrt_feeder.sv - feeds queued samples to the cube-root core and returns roots
//
// Purpose: one core operation per buffered sample via start/busy, result paired
// with its operand on a valid/ready port, per-operation watchdog, done counter.
// Ports:
//   clk, rst              : clock; synchronous active-low reset
//   in_valid/in_data/in_ready : sample input (in_ready = FIFO not full)
//   cbrt_x, cbrt_start    : operand and one-cycle launch pulse to the core
//   cbrt_busy, cbrt_result: core status and root
//   out_valid/out_ready   : result handshake
//   out_x, out_root       : operand and its floor cube root
//   out_timeout           : core hung, out_root forced to 0
//   done_count            : results accepted downstream (wraps)
module cbrt_feeder
  import cbrt_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = cbrt_pkg::TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [X_W-1:0]    in_data,
  output logic              in_ready,
  output logic [X_W-1:0]    cbrt_x,
  output logic              cbrt_start,
  input  logic              cbrt_busy,
  input  logic [ROOT_W-1:0] cbrt_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_W-1:0]    out_x,
  output logic [ROOT_W-1:0] out_root,
  output logic              out_timeout,
  output logic [CNT_W-1:0]  done_count
);

  localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  feeder_state_t   state;
  logic [X_W-1:0]  x_reg;
  logic [WD_W-1:0] watchdog;

  logic            fifo_full;
  logic            fifo_empty;
  logic [X_W-1:0]  fifo_head;
  logic            fifo_push;
  logic            fifo_pop;
  logic            launch;

  assign in_ready  = !fifo_full;
  assign fifo_push = rst && in_valid && !fifo_full;

  // A pop happens exactly when the FSM moves into START: from IDLE, or
  // back-to-back from HOLD once the current result is accepted.
  assign launch   = !fifo_empty &&
                    ((state == IDLE) || ((state == HOLD) && out_ready));
  assign fifo_pop = rst && launch;

  cbrt_in_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (X_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      x_reg       <= '0;
      watchdog    <= '0;
      cbrt_start  <= 1'b0;
      cbrt_x      <= '0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_root    <= '0;
      out_timeout <= 1'b0;
      done_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            x_reg      <= fifo_head;
            cbrt_x     <= fifo_head;
            cbrt_start <= 1'b1;
            watchdog   <= '0;
            state      <= START;
          end
        end
        START: begin
          cbrt_start <= 1'b0;
          watchdog   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          // cbrt_x is left at x_reg: the core may resample it at any time.
          if (!cbrt_busy) begin
            out_root    <= cbrt_result;
            out_x       <= x_reg;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else if (watchdog == WD_LAST) begin
            out_root    <= '0;
            out_x       <= x_reg;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            done_count <= done_count + CNT_W'(1);
            if (launch) begin
              x_reg      <= fifo_head;
              cbrt_x     <= fifo_head;
              cbrt_start <= 1'b1;
              watchdog   <= '0;
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
